cnt_seq_checker: RTL and testbench

Consumer of the free-running 8-bit counter's output stream. Samples the counter value each valid cycle, locks to the increment-by-one sequence, then flags every sample that breaks it, counts errors, and reports wrap-around. Sits beside the counter in the design as its hardware monitor and is also used in benches as a self-checking sink.

---
 rtl/cnt_seq_checker_pkg.sv | 5 +
 rtl/cnt_seq_checker.sv | 87 ++++++++
 tb/tb_cnt_seq_checker.sv | 134 +++++++++++++
 3 files changed

// File: rtl/cnt_seq_checker_pkg.sv
// cnt_seq_checker_pkg: shared types and constants for the counter-sequence checker
package cnt_seq_checker_pkg;
    typedef enum logic [1:0] {IDLE, SYNC, LOCKED} state_t;
    localparam int ERR_CNT_W = 16;
endpackage

// File: rtl/cnt_seq_checker.sv
// cnt_seq_checker: locks to an increment-by-one count stream, flags and counts breaks, reports wraps
//   clk, reset (async active-low), cnt_i/valid_i sample in, clr_i clears err_cnt_o
//   locked_o lock held, err_o/wrap_o one-cycle pulses, err_cnt_o saturating errors, expected_o next prediction
module cnt_seq_checker
    import cnt_seq_checker_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int LOCK_CNT   = 4,
    parameter int ERR_THRESH = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     cnt_i,
    input  logic                 valid_i,
    input  logic                 clr_i,
    output logic                 locked_o,
    output logic                 err_o,
    output logic                 wrap_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o,
    output logic [WIDTH-1:0]     expected_o
);
    state_t               r_state, w_next;
    logic [7:0]           r_run, r_consec, w_run, w_consec, w_run_inc, w_consec_inc;
    logic [WIDTH-1:0]     r_expected;
    logic [ERR_CNT_W-1:0] r_err_cnt, w_err_cnt;
    logic                 r_locked, r_err, r_wrap;
    logic                 w_match, w_lose, w_err, w_wrap, w_locked;

    assign w_match      = cnt_i == r_expected;
    assign w_run_inc    = r_run + 8'd1;
    assign w_consec_inc = r_consec + 8'd1;
    // the mismatch that completes the error streak drops the lock on this same edge
    assign w_lose       = valid_i && r_state == LOCKED && !w_match && w_consec_inc == 8'(ERR_THRESH);

    always_ff @(posedge clk or negedge reset)
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;

    always_comb begin
        w_next = r_state;
        if (valid_i)
            case (r_state)
                IDLE:    w_next = SYNC;
                SYNC:    w_next = (w_match && w_run_inc == 8'(LOCK_CNT)) ? LOCKED : SYNC;
                LOCKED:  w_next = w_lose ? SYNC : LOCKED;
                default: w_next = IDLE;
            endcase
    end

    always_comb begin
        w_err     = valid_i && r_state == LOCKED && !w_match;
        w_wrap    = valid_i && r_state == LOCKED && w_match && cnt_i == '0;
        w_locked  = w_next == LOCKED;
        // clear wins over the old count but still records an error seen in the same cycle
        w_err_cnt = clr_i ? ERR_CNT_W'(w_err) : r_err_cnt + ERR_CNT_W'(w_err && r_err_cnt != '1);
        w_run     = !valid_i ? r_run :
                    (r_state == SYNC && w_match) ? w_run_inc :
                    (r_state == LOCKED && !w_lose) ? r_run : 8'd1;
        w_consec  = !valid_i ? r_consec : (w_err && !w_lose) ? w_consec_inc : 8'd0;
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            r_locked   <= 1'b0;
            r_err      <= 1'b0;
            r_wrap     <= 1'b0;
            r_err_cnt  <= '0;
            r_expected <= '0;
            r_run      <= '0;
            r_consec   <= '0;
        end else begin
            r_locked  <= w_locked;
            r_err     <= w_err;
            r_wrap    <= w_wrap;
            r_err_cnt <= w_err_cnt;
            r_run     <= w_run;
            r_consec  <= w_consec;
            // every valid sample resyncs the prediction to the observed value
            if (valid_i) r_expected <= cnt_i + WIDTH'(1);
        end

    assign locked_o   = r_locked;
    assign err_o      = r_err;
    assign wrap_o     = r_wrap;
    assign err_cnt_o  = r_err_cnt;
    assign expected_o = r_expected;
endmodule

// File: tb/tb_cnt_seq_checker.sv
// tb_cnt_seq_checker: directed self-checking bench for cnt_seq_checker
module tb_cnt_seq_checker;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  cnt = '0, cnt2 = '0;
    logic        valid = 1'b0, clr = 1'b0, valid2 = 1'b0, clr2 = 1'b0;
    logic        locked, err, wrap, locked2, err2, wrap2;
    logic [15:0] err_cnt, err_cnt2;
    logic [7:0]  expected, expected2;
    int          total = 0, bad = 0;

    always #5 clk = ~clk;

    cnt_seq_checker #(.WIDTH(8), .LOCK_CNT(4), .ERR_THRESH(3)) u_dut (
        .clk(clk), .reset(reset), .cnt_i(cnt), .valid_i(valid), .clr_i(clr),
        .locked_o(locked), .err_o(err), .wrap_o(wrap), .err_cnt_o(err_cnt), .expected_o(expected)
    );

    // long error streaks without losing lock, to reach counter saturation quickly
    cnt_seq_checker #(.WIDTH(8), .LOCK_CNT(4), .ERR_THRESH(200)) u_sat (
        .clk(clk), .reset(reset), .cnt_i(cnt2), .valid_i(valid2), .clr_i(clr2),
        .locked_o(locked2), .err_o(err2), .wrap_o(wrap2), .err_cnt_o(err_cnt2), .expected_o(expected2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [7:0] c, input logic v, input logic k);
        cnt = c; valid = v; clr = k;
        @(posedge clk); #1;
    endtask

    task automatic drive2(input logic [7:0] c);
        cnt2 = c; valid2 = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        int sevens;
        repeat (3) @(posedge clk);
        #1;
        check("rst_locked", locked, 0);
        check("rst_err", err, 0);
        check("rst_wrap", wrap, 0);
        check("rst_errcnt", err_cnt, 0);
        check("rst_expected", expected, 0);
        reset = 1'b1;
        drive(0, 1, 0); check("lock_s0", locked, 0);
        drive(1, 1, 0);
        drive(2, 1, 0); check("lock_s2", locked, 0);
        drive(3, 1, 0); check("lock_s3", locked, 1);
        check("lock_errcnt", err_cnt, 0);
        check("lock_expected", expected, 4);
        drive(4, 1, 0);
        for (int i = 5; i <= 255; i++) drive(8'(i), 1, 0);
        check("pre_wrap", wrap, 0);
        drive(0, 1, 0);
        check("wrap_pulse", wrap, 1);
        check("wrap_noerr", err, 0);
        check("wrap_expected", expected, 1);
        drive(1, 1, 0); check("wrap_once", wrap, 0);
        for (int i = 2; i <= 10; i++) drive(8'(i), 1, 0);
        check("at10_locked", locked, 1);
        drive(50, 1, 0);
        check("inj_err", err, 1);
        check("inj_errcnt", err_cnt, 1);
        check("inj_locked", locked, 1);
        drive(51, 1, 0); check("inj_err_off", err, 0);
        drive(52, 1, 0);
        check("inj_expected", expected, 53);
        check("inj_errcnt2", err_cnt, 1);
        drive(7, 1, 0); check("s7a_err", err, 1); check("s7a_locked", locked, 1);
        drive(7, 1, 0); check("s7b_err", err, 1); check("s7b_locked", locked, 1);
        drive(7, 1, 0); check("s7c_err", err, 1); check("s7c_locked", locked, 0);
        check("s7c_errcnt", err_cnt, 4);
        drive(7, 1, 0); check("s7d_err", err, 0); check("s7d_errcnt", err_cnt, 4);
        drive(8, 1, 0);
        drive(9, 1, 0); check("relock_pre", locked, 0);
        drive(10, 1, 0); check("relock", locked, 1);
        drive(99, 1, 0); check("e5_errcnt", err_cnt, 5);
        drive(100, 1, 0); check("e5_noerr", err, 0);
        drive(3, 1, 1);
        check("clr_err_errcnt", err_cnt, 1);
        check("clr_err_pulse", err, 1);
        drive(4, 1, 1);
        check("clr_errcnt", err_cnt, 0);
        check("clr_locked", locked, 1);
        for (int i = 0; i < 10; i++) begin
            drive(77, 0, 0);
            check("idle_err", err, 0);
        end
        check("idle_locked", locked, 1);
        check("idle_expected", expected, 5);
        drive(5, 1, 0);
        check("resume_err", err, 0);
        check("resume_locked", locked, 1);
        drive(40, 1, 0); check("prerst_errcnt", err_cnt, 1);
        #2 reset = 1'b0;
        #1;
        check("arst_locked", locked, 0);
        check("arst_errcnt", err_cnt, 0);
        check("arst_expected", expected, 0);
        check("arst_err", err, 0);
        @(posedge clk); #1 reset = 1'b1;
        drive(41, 1, 0);
        drive(42, 1, 0);
        drive(43, 1, 0); check("post_rst_pre", locked, 0);
        drive(44, 1, 0); check("post_rst_lock", locked, 1);
        valid = 1'b0;
        drive2(0); drive2(1); drive2(2); drive2(3);
        check("sat_locked", locked2, 1);
        sevens = 0;
        for (int k = 0; sevens < 65534; k++) begin
            if (k % 150 == 149) drive2(8);
            else begin
                drive2(7);
                sevens++;
            end
        end
        check("sat_pre", err_cnt2, 16'hFFFE);
        check("sat_pre_locked", locked2, 1);
        drive2(7); check("sat_full", err_cnt2, 16'hFFFF);
        drive2(7);
        check("sat_hold", err_cnt2, 16'hFFFF);
        check("sat_err", err2, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
